// File: rtl/sp_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sp_ram_ctrl
// Summary  : Single-port synchronous RAM with request/ready interface, byte
//            write enables, self-clear after reset and 1- or 2-cycle reads.
//            Optional macro SP_RAM_PARITY_EN adds per-byte even parity with
//            mc_perr_inj / mem_perr.
// Revision : 1.0  initial release
// ============================================================================
module sp_ram_ctrl #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 6,
    parameter int READ_LAT = 1
) (
    input  logic                mem_clk,
    input  logic                mem_rst_n,
    input  logic                mc_req,
    input  logic                mc_we,
    input  logic [DATA_W/8-1:0] mc_be,
    input  logic [ADDR_W-1:0]   mc_address_mem,
    input  logic [DATA_W-1:0]   mem_data_in,
    output logic                mem_ready,
    output logic [DATA_W-1:0]   mem_data_out,
    output logic                mem_rvalid,
    output logic                mem_init_done
`ifdef SP_RAM_PARITY_EN
    ,
    input  logic                mc_perr_inj,
    output logic                mem_perr
`endif
);

    localparam int C_NB    = DATA_W / 8;
    localparam int C_DEPTH = 1 << ADDR_W;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_init_cnt;
    logic                r_ready;
    logic                r_init_done;

    logic                w_init;
    logic                w_accept;
    logic                w_wr;
    logic                w_rd;

    assign w_init   = (r_state == ST_INIT);
    assign w_accept = mc_req & r_ready;
    assign w_wr     = w_accept & mc_we;
    assign w_rd     = w_accept & ~mc_we;

    // Clear sequence: one word per cycle, then RUN for good
    always_ff @(posedge mem_clk or negedge mem_rst_n) begin
        if (!mem_rst_n) begin
            r_state     <= ST_INIT;
            r_init_cnt  <= '0;
            r_ready     <= 1'b0;
            r_init_done <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_init_cnt <= r_init_cnt + 1'b1;
                    if (r_init_cnt == '1) begin
                        r_state     <= ST_RUN;
                        r_ready     <= 1'b1;
                        r_init_done <= 1'b1;
                    end
                end
                ST_RUN: begin
                    r_ready     <= 1'b1;
                    r_init_done <= 1'b1;
                end
                default: begin
                    r_state <= ST_INIT;
                end
            endcase
        end
    end

    // Storage array carries no reset; the INIT walk provides the clear
    logic [DATA_W-1:0] r_mem [C_DEPTH];

    always_ff @(posedge mem_clk) begin
        if (w_init) begin
            r_mem[r_init_cnt] <= '0;
        end else if (w_wr) begin
            for (int i = 0; i < C_NB; i++) begin
                if (mc_be[i]) begin
                    r_mem[mc_address_mem][8*i +: 8] <= mem_data_in[8*i +: 8];
                end
            end
        end
    end

`ifdef SP_RAM_PARITY_EN
    logic [C_NB-1:0] r_par [C_DEPTH];

    always_ff @(posedge mem_clk) begin
        if (w_init) begin
            r_par[r_init_cnt] <= '0;
        end else if (w_wr) begin
            for (int i = 0; i < C_NB; i++) begin
                if (mc_be[i]) begin
                    r_par[mc_address_mem][i] <= (^mem_data_in[8*i +: 8]) ^ mc_perr_inj;
                end
            end
        end
    end
`endif

    // Read address stage: the array is read one edge after acceptance,
    // so a write accepted the cycle before is already visible.
    logic              r_rd_pend;
    logic [ADDR_W-1:0] r_raddr;

    always_ff @(posedge mem_clk or negedge mem_rst_n) begin
        if (!mem_rst_n) begin
            r_rd_pend <= 1'b0;
            r_raddr   <= '0;
        end else begin
            r_rd_pend <= w_rd;
            if (w_rd) begin
                r_raddr <= mc_address_mem;
            end
        end
    end

    logic [DATA_W-1:0] w_rdata;
    assign w_rdata = r_mem[r_raddr];

`ifdef SP_RAM_PARITY_EN
    logic [C_NB-1:0] w_rpar;
    logic            w_rperr;
    assign w_rpar = r_par[r_raddr];

    always_comb begin
        w_rperr = 1'b0;
        for (int i = 0; i < C_NB; i++) begin
            if (^{w_rdata[8*i +: 8], w_rpar[i]}) begin
                w_rperr = 1'b1;
            end
        end
    end

    logic r_perr;
    assign mem_perr = r_perr;
`endif

    logic              r_rvalid;
    logic [DATA_W-1:0] r_data_out;

    generate
        if (READ_LAT == 2) begin : g_lat2
            logic              r_s1_valid;
            logic [DATA_W-1:0] r_s1_data;
`ifdef SP_RAM_PARITY_EN
            logic              r_s1_perr;
`endif

            always_ff @(posedge mem_clk or negedge mem_rst_n) begin
                if (!mem_rst_n) begin
                    r_s1_valid <= 1'b0;
                    r_s1_data  <= '0;
                    r_rvalid   <= 1'b0;
                    r_data_out <= '0;
`ifdef SP_RAM_PARITY_EN
                    r_s1_perr  <= 1'b0;
                    r_perr     <= 1'b0;
`endif
                end else begin
                    r_s1_valid <= r_rd_pend;
                    if (r_rd_pend) begin
                        r_s1_data <= w_rdata;
                    end
                    r_rvalid <= r_s1_valid;
                    if (r_s1_valid) begin
                        r_data_out <= r_s1_data;
                    end
`ifdef SP_RAM_PARITY_EN
                    r_s1_perr <= r_rd_pend & w_rperr;
                    r_perr    <= r_s1_valid & r_s1_perr;
`endif
                end
            end
        end else begin : g_lat1
            always_ff @(posedge mem_clk or negedge mem_rst_n) begin
                if (!mem_rst_n) begin
                    r_rvalid   <= 1'b0;
                    r_data_out <= '0;
`ifdef SP_RAM_PARITY_EN
                    r_perr     <= 1'b0;
`endif
                end else begin
                    r_rvalid <= r_rd_pend;
                    if (r_rd_pend) begin
                        r_data_out <= w_rdata;
                    end
`ifdef SP_RAM_PARITY_EN
                    r_perr <= r_rd_pend & w_rperr;
`endif
                end
            end
        end
    endgenerate

    assign mem_ready     = r_ready;
    assign mem_init_done = r_init_done;
    assign mem_rvalid    = r_rvalid;
    assign mem_data_out  = r_data_out;

endmodule
`default_nettype wire

// File: tb/tb_sp_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sp_ram_ctrl
// Summary  : Scoreboard bench driving one READ_LAT=1 and one READ_LAT=2
//            instance of sp_ram_ctrl from shared stimulus.
// Revision : 1.0  initial release
// ============================================================================
module tb_sp_ram_ctrl;

    localparam int DW    = 32;
    localparam int AW    = 6;
    localparam int DEPTH = 64;

    logic          mem_clk        = 1'b0;
    logic          mem_rst_n      = 1'b0;
    logic          mc_req         = 1'b0;
    logic          mc_we          = 1'b0;
    logic [3:0]    mc_be          = '0;
    logic [AW-1:0] mc_address_mem = '0;
    logic [DW-1:0] mem_data_in    = '0;

    logic          rdy  [2];
    logic          rv   [2];
    logic          done [2];
    logic [DW-1:0] dout [2];
`ifdef SP_RAM_PARITY_EN
    logic          mc_perr_inj = 1'b0;
    logic          perr [2];
`endif

    sp_ram_ctrl #(.DATA_W(DW), .ADDR_W(AW), .READ_LAT(1)) u_lat1 (
        .mem_clk        (mem_clk),
        .mem_rst_n      (mem_rst_n),
        .mc_req         (mc_req),
        .mc_we          (mc_we),
        .mc_be          (mc_be),
        .mc_address_mem (mc_address_mem),
        .mem_data_in    (mem_data_in),
        .mem_ready      (rdy[0]),
        .mem_data_out   (dout[0]),
        .mem_rvalid     (rv[0]),
        .mem_init_done  (done[0])
`ifdef SP_RAM_PARITY_EN
        ,
        .mc_perr_inj    (mc_perr_inj),
        .mem_perr       (perr[0])
`endif
    );

    sp_ram_ctrl #(.DATA_W(DW), .ADDR_W(AW), .READ_LAT(2)) u_lat2 (
        .mem_clk        (mem_clk),
        .mem_rst_n      (mem_rst_n),
        .mc_req         (mc_req),
        .mc_we          (mc_we),
        .mc_be          (mc_be),
        .mc_address_mem (mc_address_mem),
        .mem_data_in    (mem_data_in),
        .mem_ready      (rdy[1]),
        .mem_data_out   (dout[1]),
        .mem_rvalid     (rv[1]),
        .mem_init_done  (done[1])
`ifdef SP_RAM_PARITY_EN
        ,
        .mc_perr_inj    (mc_perr_inj),
        .mem_perr       (perr[1])
`endif
    );

    always #5 mem_clk = ~mem_clk;

    int unsigned cyc = 0;
    always @(posedge mem_clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] due;
    } exp_t;

    exp_t          q0[$];
    exp_t          q1[$];
    logic [DW-1:0] model [DEPTH];

    // Scoreboard: every rvalid must match the oldest expected read and its due cycle
    task automatic sb_lane(input int l);
        exp_t e;
        int   n;
        n = (l == 0) ? q0.size() : q1.size();
        if (rv[l] !== 1'b0 && rv[l] !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL rvalid_unknown lane%0d cyc %0d: got %b, required 0 or 1", l, cyc, rv[l]);
        end else if (rv[l] === 1'b1) begin
            checks++;
            if (n == 0) begin
                errors++;
                $display("FAIL rvalid_spurious lane%0d cyc %0d: got rvalid data=%h, required no rvalid", l, cyc, dout[l]);
            end else begin
                if (l == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                if (e.due != cyc || dout[l] !== e.data) begin
                    errors++;
                    $display("FAIL read_data lane%0d: got %h at cyc %0d, required %h at cyc %0d",
                             l, dout[l], cyc, e.data, e.due);
                end
            end
        end else if (n > 0) begin
            if (l == 0) e = q0[0];
            else        e = q1[0];
            if (e.due < cyc) begin
                checks++;
                errors++;
                $display("FAIL read_missing lane%0d cyc %0d: got no rvalid, required data %h at cyc %0d",
                         l, cyc, e.data, e.due);
                if (l == 0) void'(q0.pop_front());
                else        void'(q1.pop_front());
            end
        end
    endtask

    always @(negedge mem_clk) begin
        sb_lane(0);
        sb_lane(1);
    end

    task automatic step();
        @(posedge mem_clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        q0.delete();
        q1.delete();
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
        for (int i = 0; i < 4; i++) begin
            if (be[i]) model[a][8*i +: 8] = d[8*i +: 8];
        end
        mc_req = 1'b1; mc_we = 1'b1; mc_address_mem = a; mem_data_in = d; mc_be = be;
        step();
        mc_req = 1'b0; mc_we = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a);
        exp_t e;
        e.data = model[a];
        e.due  = cyc + 2;
        q0.push_back(e);
        e.due  = cyc + 3;
        q1.push_back(e);
        mc_req = 1'b1; mc_we = 1'b0; mc_address_mem = a;
        mem_data_in = $urandom; mc_be = 4'($urandom);
        step();
        mc_req = 1'b0;
    endtask

    task automatic test_reset();
        mem_rst_n = 1'b0;
        model_clear();
        repeat (3) step();
        @(negedge mem_clk);
        for (int l = 0; l < 2; l++) begin
            checks++;
            if (rdy[l] !== 1'b0) begin errors++; $display("FAIL reset_ready lane%0d: got %b, required 0", l, rdy[l]); end
            checks++;
            if (rv[l] !== 1'b0) begin errors++; $display("FAIL reset_rvalid lane%0d: got %b, required 0", l, rv[l]); end
            checks++;
            if (dout[l] !== 32'h0) begin errors++; $display("FAIL reset_data lane%0d: got %h, required 00000000", l, dout[l]); end
            checks++;
            if (done[l] !== 1'b0) begin errors++; $display("FAIL reset_init_done lane%0d: got %b, required 0", l, done[l]); end
        end
        step();
    endtask

    task automatic test_init();
        // Requests held high throughout INIT must be ignored
        mem_rst_n = 1'b1;
        mc_req = 1'b1; mc_we = 1'b0; mc_address_mem = 6'd5;
        repeat (DEPTH - 1) step();
        @(negedge mem_clk);
        for (int l = 0; l < 2; l++) begin
            checks++;
            if (rdy[l] !== 1'b0 || done[l] !== 1'b0) begin
                errors++;
                $display("FAIL init_early lane%0d: got ready=%b done=%b after 63 cycles, required 0/0", l, rdy[l], done[l]);
            end
        end
        step();
        mc_req = 1'b0;
        @(negedge mem_clk);
        for (int l = 0; l < 2; l++) begin
            checks++;
            if (rdy[l] !== 1'b1 || done[l] !== 1'b1) begin
                errors++;
                $display("FAIL init_done lane%0d: got ready=%b done=%b after 64 cycles, required 1/1", l, rdy[l], done[l]);
            end
        end
        step();
        do_read(6'd0);
        do_read(6'd31);
        do_read(6'd63);
        repeat (4) step();
    endtask

    task automatic test_byte_en();
        do_write(6'd5, 32'hAABBCCDD, 4'b1111);
        do_write(6'd5, 32'h00001100, 4'b0010);
        repeat (2) step();
        do_read(6'd5);
        repeat (4) step();
    endtask

    task automatic test_back_to_back();
        do_write(6'd0, 32'h11111111, 4'b1111);
        do_write(6'd1, 32'h22222222, 4'b1111);
        do_write(6'd2, 32'h33333333, 4'b1111);
        do_write(6'd63, 32'h12345678, 4'b1111);
        do_read(6'd63);
        do_read(6'd0);
        do_read(6'd1);
        do_read(6'd2);
        repeat (4) step();
        @(negedge mem_clk);
        for (int l = 0; l < 2; l++) begin
            checks++;
            if (dout[l] !== 32'h33333333) begin
                errors++;
                $display("FAIL data_hold lane%0d: got %h, required 33333333", l, dout[l]);
            end
        end
        step();
    endtask

    task automatic test_write_noop();
        do_write(6'd7, 32'hFFFFFFFF, 4'b0000);
        repeat (3) step();
        do_read(6'd7);
        repeat (4) step();
    endtask

    task automatic test_reset_mid();
        do_read(6'd5);
        // Read accepted on the previous edge; kill it before rvalid
        mem_rst_n = 1'b0;
        model_clear();
        @(negedge mem_clk);
        for (int l = 0; l < 2; l++) begin
            checks++;
            if (rv[l] !== 1'b0 || dout[l] !== 32'h0 || rdy[l] !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid lane%0d: got rvalid=%b data=%h ready=%b, required 0/00000000/0",
                         l, rv[l], dout[l], rdy[l]);
            end
        end
        step();
        step();
        mem_rst_n = 1'b1;
        repeat (DEPTH) step();
        @(negedge mem_clk);
        for (int l = 0; l < 2; l++) begin
            checks++;
            if (rdy[l] !== 1'b1) begin
                errors++;
                $display("FAIL reinit_ready lane%0d: got %b, required 1", l, rdy[l]);
            end
        end
        step();
        do_read(6'd5);
        repeat (4) step();
    endtask

`ifdef SP_RAM_PARITY_EN
    task automatic test_parity();
        for (int inj = 1; inj >= 0; inj--) begin
            mc_perr_inj = inj[0];
            do_write(6'd9, 32'h01020304, 4'b1111);
            mc_perr_inj = 1'b0;
            do_read(6'd9);
            step();
            @(negedge mem_clk);
            checks++;
            if (rv[0] !== 1'b1 || perr[0] !== inj[0]) begin
                errors++;
                $display("FAIL parity lane0 inj=%0d: got rvalid=%b perr=%b, required 1/%0d", inj, rv[0], perr[0], inj);
            end
            step();
            @(negedge mem_clk);
            checks++;
            if (rv[1] !== 1'b1 || perr[1] !== inj[0]) begin
                errors++;
                $display("FAIL parity lane1 inj=%0d: got rvalid=%b perr=%b, required 1/%0d", inj, rv[1], perr[1], inj);
            end
            step();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_init();
        test_byte_en();
        test_back_to_back();
        test_write_noop();
        test_reset_mid();
`ifdef SP_RAM_PARITY_EN
        test_parity();
`endif
        repeat (6) step();
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d/%0d reads outstanding, required 0/0", q0.size(), q1.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000 time units, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
